// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and data (D) requesters.
// Optional build macro ARB_RR_EN: alternate the grant on contended arbitrations.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MODE_W-1:0] d_mode,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_i,
    output logic              stall_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MODE_W-1:0] mem_mode,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [MODE_W-1:0] WORD_MODE = MODE_W'(3'b010);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, nextState;

    logic              ownerD;
    logic              killFlag;
    logic              killHit;
    logic              killAny;
    logic              latchCmd;
    logic              grantD;
    logic              respDone;
    logic              preferD;
    logic              memReqR;
    logic              iValidR;
    logic              dValidR;
    logic [DATA_W-1:0] iRdataR;
    logic [DATA_W-1:0] dRdataR;
    logic              memWeR;
    logic [ADDR_W-1:0] memAddrR;
    logic [DATA_W-1:0] memWdataR;
    logic [MODE_W-1:0] memModeR;

`ifdef ARB_RR_EN
    logic lastWinnerD;

    // Remembers who won the last contended arbitration (reset favours I as last winner).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastWinnerD <= 1'b0;
        end else if (latchCmd && i_req && d_req) begin
            lastWinnerD <= grantD;
        end
    end

    assign preferD = ~lastWinnerD;
`else
    assign preferD = 1'b1;
`endif

    // A kill only matters while a fetch owns the memory handshake.
    assign killHit = i_kill && !ownerD && ((state == ISSUE) || (state == WAIT));
    assign killAny = killFlag || killHit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, arbitration and response-completion decode.
    always_comb begin
        nextState = state;
        latchCmd  = 1'b0;
        grantD    = 1'b0;
        respDone  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    latchCmd  = 1'b1;
                    grantD    = d_req && (!i_req || preferD);
                    nextState = ISSUE;
                end else begin
                    nextState = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        respDone  = 1'b1;
                        nextState = RESP;
                    end else begin
                        nextState = WAIT;
                    end
                end else begin
                    nextState = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    respDone  = 1'b1;
                    nextState = RESP;
                end else begin
                    nextState = WAIT;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Command latch, owner/kill tracking, response pulses and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReqR   <= 1'b0;
            ownerD    <= 1'b0;
            killFlag  <= 1'b0;
            iValidR   <= 1'b0;
            dValidR   <= 1'b0;
            iRdataR   <= '0;
            dRdataR   <= '0;
            memWeR    <= 1'b0;
            memAddrR  <= '0;
            memWdataR <= '0;
            memModeR  <= '0;
        end else begin
            memReqR <= (nextState == ISSUE);
            iValidR <= respDone && !ownerD && !killAny;
            dValidR <= respDone && ownerD;
            if (latchCmd) begin
                ownerD    <= grantD;
                killFlag  <= 1'b0;
                memWeR    <= grantD ? d_we : 1'b0;
                memAddrR  <= grantD ? d_addr : i_addr;
                memWdataR <= grantD ? d_wdata : '0;
                memModeR  <= grantD ? d_mode : WORD_MODE;
            end else if (killHit) begin
                killFlag <= 1'b1;
            end
            // A killed fetch keeps the previous instruction word visible.
            if (respDone && !ownerD && !killAny) begin
                iRdataR <= mem_rdata;
            end
            if (respDone && ownerD && !memWeR) begin
                dRdataR <= mem_rdata;
            end
        end
    end

    assign mem_req   = memReqR;
    assign mem_we    = memWeR;
    assign mem_addr  = memAddrR;
    assign mem_wdata = memWdataR;
    assign mem_mode  = memModeR;
    assign i_valid   = iValidR;
    assign d_valid   = dValidR;
    assign i_rdata   = iRdataR;
    assign d_rdata   = dRdataR;
    assign stall_i   = i_req && !iValidR;
    assign stall_d   = d_req && !dValidR;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model. Honours ARB_RR_EN when defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_kill, i_valid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_mode;
    logic        stall_i, stall_d;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mode;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
        .d_valid(d_valid), .d_rdata(d_rdata), .stall_i(stall_i), .stall_d(stall_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mode(mem_mode), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents: one pinned instruction word, everything else derived from the address.
    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0051_0513;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] randAddr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit randMode  = 1'b0;
    int holdReady = 0;
    bit rOut      = 1'b0;
    int rDelay    = 0;
    int dly;

    always @(posedge clk) begin
        #1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rst) begin
            rOut = 1'b0;
        end else if (rOut) begin
            if (rDelay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memData(mem_addr);
                rOut       = 1'b0;
            end else begin
                rDelay--;
            end
        end else if (mem_req) begin
            if (holdReady > 0) begin
                holdReady--;
            end else if (!randMode || $urandom_range(0, 3) != 0) begin
                mem_ready = 1'b1;
                dly = randMode ? int'($urandom_range(0, 2)) : 1;
                if (dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = memData(mem_addr);
                end else begin
                    rOut   = 1'b1;
                    rDelay = dly - 1;
                end
            end
        end else if (randMode && $urandom_range(0, 15) == 0) begin
            mem_rvalid = 1'b1;
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit          mBusy, mAcc, mPulse, mD, mKilled, mWe, mLastD, done, takeD;
    logic [31:0] mAddr, mWdata, mIR, mDR;
    logic [2:0]  mMode;
    bit          expIV, expDV;
    int          nDoneI = 0;
    int          nDoneD = 0;

    always @(negedge clk) begin
        if (rst) begin
            mBusy = 0; mAcc = 0; mPulse = 0; mD = 0; mKilled = 0; mWe = 0; mLastD = 0;
            mAddr = '0; mWdata = '0; mMode = '0; mIR = '0; mDR = '0;
        end else begin
            expIV = mPulse && !mD && !mKilled;
            expDV = mPulse && mD;
            check("mem_req", 32'(mem_req), 32'(mBusy && !mAcc));
            check("mem_we", 32'(mem_we), 32'(mWe));
            check("mem_addr", mem_addr, mAddr);
            check("mem_mode", 32'(mem_mode), 32'(mMode));
            if (mWe) check("mem_wdata", mem_wdata, mWdata);
            check("i_valid", 32'(i_valid), 32'(expIV));
            check("d_valid", 32'(d_valid), 32'(expDV));
            check("i_rdata", i_rdata, mIR);
            check("d_rdata", d_rdata, mDR);
            check("stall_i", 32'(stall_i), 32'(i_req && !expIV));
            check("stall_d", 32'(stall_d), 32'(d_req && !expDV));
            // Advance: one transaction at a time, response cycle ignores everything.
            done = 1'b0;
            if (mPulse) begin
                mPulse = 1'b0;
            end else if (mBusy) begin
                if (!mD && i_kill) mKilled = 1'b1;
                if (!mAcc) begin
                    if (mem_ready) begin
                        mAcc = 1'b1;
                        if (mem_rvalid) done = 1'b1;
                    end
                end else if (mem_rvalid) begin
                    done = 1'b1;
                end
                if (done) begin
                    mBusy  = 1'b0;
                    mPulse = 1'b1;
                    if (mD) nDoneD++; else nDoneI++;
                    if (!mWe) begin
                        if (mD) mDR = memData(mAddr);
                        else if (!mKilled) mIR = memData(mAddr);
                    end
                end
            end else if (i_req || d_req) begin
                takeD = d_req;
`ifdef ARB_RR_EN
                if (i_req && d_req) begin
                    takeD  = !mLastD;
                    mLastD = takeD;
                end
`endif
                mBusy = 1'b1; mAcc = 1'b0; mKilled = 1'b0; mD = takeD;
                mWe    = takeD ? d_we : 1'b0;
                mAddr  = takeD ? d_addr : i_addr;
                mMode  = takeD ? d_mode : 3'b010;
                mWdata = d_wdata;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic newD();
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = randAddr();
        d_wdata = $urandom;
        d_mode  = 3'($urandom_range(0, 7));
    endtask

    task automatic randStep();
        i_kill = 1'b0;
        if (i_req && i_valid) begin
            if ($urandom_range(0, 1) == 0) i_req = 1'b0; else i_addr = randAddr();
        end else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = randAddr();
        end
        if (i_req && $urandom_range(0, 19) == 0) begin
            i_kill = 1'b1;
            i_addr = randAddr();
        end
        if (d_req && d_valid) begin
            if ($urandom_range(0, 1) == 0) d_req = 1'b0; else newD();
        end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1;
            newD();
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Simultaneous fetch (0x10) and load (0x100); dFirst says who must be served first.
    task automatic contention(input bit dFirst);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_mode = 3'b100;
        @(negedge clk);
        check("cont_stall_i", 32'(stall_i), 32'd1);
        check("cont_stall_d", 32'(stall_d), 32'd1);
        @(negedge clk);
        check("cont_first_addr", mem_addr, dFirst ? 32'h0000_0100 : 32'h0000_0010);
        repeat (2) @(negedge clk);
        check("cont_first_dv", 32'(d_valid), dFirst ? 32'd1 : 32'd0);
        check("cont_first_iv", 32'(i_valid), dFirst ? 32'd0 : 32'd1);
        check("cont_stall_other", 32'(dFirst ? stall_i : stall_d), 32'd1);
        @(posedge clk); #1;
        if (dFirst) d_req = 1'b0; else i_req = 1'b0;
        repeat (2) @(negedge clk);
        check("cont_second_addr", mem_addr, dFirst ? 32'h0000_0010 : 32'h0000_0100);
        repeat (2) @(negedge clk);
        check("cont_second_iv", 32'(i_valid), dFirst ? 32'd1 : 32'd0);
        check("cont_second_dv", 32'(d_valid), dFirst ? 32'd0 : 32'd1);
        check("cont_d_rdata", d_rdata, 32'h0100_FEFF);
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mode = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_i_valid", 32'(i_valid), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_mode", 32'(mem_mode), 32'd0);
        @(posedge clk); #3; rst = 1'b0;

        // Lone fetch: valid three cycles after the request.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        @(negedge clk);
        check("t1_stall_i", 32'(stall_i), 32'd1);
        @(negedge clk);
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h0000_0010);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        check("t1_mem_mode", 32'(mem_mode), 32'd2);
        @(negedge clk);
        check("t1_no_early_valid", 32'(i_valid), 32'd0);
        @(negedge clk);
        check("t1_i_valid", 32'(i_valid), 32'd1);
        check("t1_i_rdata", i_rdata, 32'h0051_0513);
        check("t1_stall_i_drop", 32'(stall_i), 32'd0);
        idle(2);

        contention(1'b1);
`ifdef ARB_RR_EN
        contention(1'b0);
`else
        contention(1'b1);
`endif

        // Store: command carries the store fields, d_rdata untouched.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF; d_mode = 3'b000;
        repeat (2) @(negedge clk);
        check("t3_mem_we", 32'(mem_we), 32'd1);
        check("t3_mem_addr", mem_addr, 32'h0000_0200);
        check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t3_mem_mode", 32'(mem_mode), 32'd0);
        repeat (2) @(negedge clk);
        check("t3_d_valid", 32'(d_valid), 32'd1);
        check("t3_d_rdata", d_rdata, 32'h0100_FEFF);
        idle(2);

        // Kill during WAIT, then redirected fetch to 0x14.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0020;
        @(posedge clk);
        @(posedge clk); #1;
        i_kill = 1'b1; i_addr = 32'h0000_0014;
        @(posedge clk); #1;
        i_kill = 1'b0;
        @(negedge clk);
        check("t4_killed_valid", 32'(i_valid), 32'd0);
        check("t4_rdata_kept", i_rdata, 32'h0051_0513);
        @(negedge clk);
        check("t4_idle", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("t4_refetch_addr", mem_addr, 32'h0000_0014);
        repeat (2) @(negedge clk);
        check("t4_refetch_valid", 32'(i_valid), 32'd1);
        check("t4_refetch_data", i_rdata, 32'h0014_FFEB);
        idle(2);

        // Backpressure: five cycles without mem_ready.
        holdReady = 5;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; d_mode = 3'b001;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_hold_req", 32'(mem_req), 32'd1);
            check("t5_hold_addr", mem_addr, 32'h0000_0040);
            check("t5_stall_d", 32'(stall_d), 32'd1);
        end
        @(negedge clk);
        check("t5_accept_req", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        check("t5_d_valid", 32'(d_valid), 32'd1);
        check("t5_d_rdata", d_rdata, 32'h0040_FFBF);
        idle(2);

        // Asynchronous reset while the fetch sits in WAIT.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0030;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t6_mem_req", 32'(mem_req), 32'd0);
        check("t6_i_valid", 32'(i_valid), 32'd0);
        check("t6_d_valid", 32'(d_valid), 32'd0);
        check("t6_i_rdata", i_rdata, 32'd0);
        check("t6_d_rdata", d_rdata, 32'd0);
        check("t6_mem_addr", mem_addr, 32'd0);
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #3; rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_idle_after", 32'(mem_req), 32'd0);

        // Randomized traffic with random memory timing, stray responses and kills.
        randMode = 1'b1;
        repeat (3000) begin
            @(posedge clk); #1;
            randStep();
        end
        idle(8);
        check("rand_progress_i", 32'(nDoneI > 50), 32'd1);
        check("rand_progress_d", 32'(nDoneD > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
